// File: rtl/window_feeder.sv
// window_feeder: write-side controller for the scan-in shift window.
// Accepts a byte stream (valid/ready), shifts it into the window, raises
// win_valid when a complete set of taps is present and holds the stream off
// until the compute engine acknowledges. Between windows of a row only STRIDE
// new bytes are shifted in, so older taps are reused.
// Optional feature: define FEEDER_ZPAD_EN to insert PAD leading zero bytes at
// every row start (reset, row end, row error).
module window_feeder #(
    parameter int WIN    = 19,
    parameter int STRIDE = 1,
    parameter int PAD    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       wen,
    output logic [7:0] din,
    output logic       win_valid,
    input  logic       win_ack,
    output logic [7:0] win_idx,
    output logic       row_err
);

    localparam int NEED_W = $clog2(WIN + 1);
    localparam logic [NEED_W-1:0] NEED_FULL   = NEED_W'(WIN);
    localparam logic [NEED_W-1:0] NEED_STRIDE = NEED_W'(STRIDE);
    localparam logic [NEED_W-1:0] NEED_ONE    = NEED_W'(1);

    typedef enum logic [1:0] {
        ST_PAD   = 2'd0,
        ST_FILL  = 2'd1,
        ST_VALID = 2'd2
    } st_t;

`ifdef FEEDER_ZPAD_EN
    // Rows start by injecting zeros unless no padding is configured.
    localparam st_t ROW_START = (PAD > 0) ? ST_PAD : ST_FILL;
    // need counts down from WIN through the pad phase; the pad phase ends on
    // the cycle need still holds WIN-PAD+1, leaving WIN-PAD stream bytes.
    localparam logic [NEED_W-1:0] NEED_PAD_LAST = NEED_W'(WIN - PAD + 1);
`else
    localparam st_t ROW_START = ST_FILL;
`endif

    // Elaboration-time parameter range checks.
    if (STRIDE < 1 || STRIDE > WIN) begin : g_bad_stride
        $error("window_feeder: STRIDE must be within 1..WIN");
    end
    if (PAD < 0 || PAD >= WIN) begin : g_bad_pad
        $error("window_feeder: PAD must be within 0..WIN-1");
    end

    st_t               st_q, st_d;
    logic [NEED_W-1:0] need_q, need_d;
    logic              row_end_q, row_end_d;
    logic [7:0]        win_idx_q, win_idx_d;
    logic              row_err_q, row_err_d;
    logic              s_ready_q, s_ready_d;
    logic              win_valid_q, win_valid_d;
`ifdef FEEDER_ZPAD_EN
    logic              pad_q, pad_d;
`endif

    logic hs;
    assign hs = s_valid && s_ready_q;

    // Next-state and counter logic for the pad / fill / valid sequence.
    always_comb begin
        st_d      = st_q;
        need_d    = need_q;
        row_end_d = row_end_q;
        win_idx_d = win_idx_q;
        row_err_d = 1'b0;
        case (st_q)
`ifdef FEEDER_ZPAD_EN
            ST_PAD: begin
                need_d = need_q - NEED_ONE;
                if (need_q == NEED_PAD_LAST) begin
                    st_d = ST_FILL;
                end
            end
`endif
            ST_FILL: begin
                if (hs) begin
                    need_d = need_q - NEED_ONE;
                    if (need_q == NEED_ONE) begin
                        st_d      = ST_VALID;
                        row_end_d = s_last;
                    end else if (s_last) begin
                        // Row ended before the window filled: drop it and restart.
                        row_err_d = 1'b1;
                        st_d      = ROW_START;
                        need_d    = NEED_FULL;
                        win_idx_d = 8'd0;
                    end
                end
            end
            ST_VALID: begin
                if (win_ack) begin
                    if (row_end_q) begin
                        row_end_d = 1'b0;
                        st_d      = ROW_START;
                        need_d    = NEED_FULL;
                        win_idx_d = 8'd0;
                    end else begin
                        st_d      = ST_FILL;
                        need_d    = NEED_STRIDE;
                        win_idx_d = win_idx_q + 8'd1;
                    end
                end
            end
            default: begin
                st_d   = ROW_START;
                need_d = NEED_FULL;
            end
        endcase
    end

    // Output decodes of the next state, registered alongside the state.
    always_comb begin
        s_ready_d   = (st_d == ST_FILL);
        win_valid_d = (st_d == ST_VALID);
`ifdef FEEDER_ZPAD_EN
        pad_d       = (st_d == ST_PAD);
`endif
    end

    // State, counters and registered outputs; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ROW_START;
            need_q      <= NEED_FULL;
            row_end_q   <= 1'b0;
            win_idx_q   <= 8'd0;
            row_err_q   <= 1'b0;
            s_ready_q   <= (ROW_START == ST_FILL);
            win_valid_q <= 1'b0;
`ifdef FEEDER_ZPAD_EN
            pad_q       <= (ROW_START == ST_PAD);
`endif
        end else begin
            st_q        <= st_d;
            need_q      <= need_d;
            row_end_q   <= row_end_d;
            win_idx_q   <= win_idx_d;
            row_err_q   <= row_err_d;
            s_ready_q   <= s_ready_d;
            win_valid_q <= win_valid_d;
`ifdef FEEDER_ZPAD_EN
            pad_q       <= pad_d;
`endif
        end
    end

    // Window write port is combinational so the shift lands on the handshake edge.
    always_comb begin
`ifdef FEEDER_ZPAD_EN
        wen = pad_q || (s_ready_q && s_valid);
`else
        wen = s_ready_q && s_valid;
`endif
        din = s_ready_q ? s_data : 8'd0;
    end

    assign s_ready   = s_ready_q;
    assign win_valid = win_valid_q;
    assign win_idx   = win_idx_q;
    assign row_err   = row_err_q;

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: directed bench for window_feeder. Two instances share the
// clock and reset: u_a with STRIDE=1 and u_b with STRIDE=4. Each drives a
// behavioural model of the 19-byte shift window from its wen/din.
module tb_window_feeder;
    localparam int WIN = 19;
    localparam int PAD = 9;
`ifdef FEEDER_ZPAD_EN
    localparam int NPAD = PAD;
`else
    localparam int NPAD = 0;
`endif
    localparam int NSTREAM = WIN - NPAD;
    localparam int LIM = 200;

    typedef logic [WIN*8-1:0] win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_valid = 1'b0, a_last = 1'b0, a_ack = 1'b0;
    logic [7:0] a_data = 8'd0;
    logic       a_ready, a_wen, a_wvalid, a_err;
    logic [7:0] a_din, a_idx;

    logic       b_valid = 1'b0, b_last = 1'b0, b_ack = 1'b0;
    logic [7:0] b_data = 8'd0;
    logic       b_ready, b_wen, b_wvalid, b_err;
    logic [7:0] b_din, b_idx;

    win_t a_win = '0;
    win_t b_win = '0;
    win_t e_win;
    int   n_chk = 0;
    int   n_bad = 0;
    int   holdbad = 0;

    window_feeder #(.WIN(WIN), .STRIDE(1), .PAD(PAD)) u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_data(a_data),
        .s_last(a_last), .s_ready(a_ready), .wen(a_wen), .din(a_din),
        .win_valid(a_wvalid), .win_ack(a_ack), .win_idx(a_idx), .row_err(a_err)
    );

    window_feeder #(.WIN(WIN), .STRIDE(4), .PAD(PAD)) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_data(b_data),
        .s_last(b_last), .s_ready(b_ready), .wen(b_wen), .din(b_din),
        .win_valid(b_wvalid), .win_ack(b_ack), .win_idx(b_idx), .row_err(b_err)
    );

    always #5 clk = ~clk;

    // Shift window models: new byte enters at the high end, oldest at byte 0.
    always @(posedge clk) if (a_wen) a_win <= {a_din, a_win[WIN*8-1:8]};
    always @(posedge clk) if (b_wen) b_win <= {b_din, b_win[WIN*8-1:8]};

    function automatic win_t exp_win(input int nz, input int first);
        win_t w = '0;
        for (int k = 0; k < WIN; k++)
            if (k >= nz) w[k*8 +: 8] = 8'(first + k - nz);
        return w;
    endfunction

    task automatic chk(input string tag, input win_t obs, input win_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic last);
        int n = 0;
        a_valid = 1'b1; a_data = d; a_last = last;
        while (!a_ready && n < LIM) begin tick(); n++; end
        if (n >= LIM) chk("a_send_timeout", win_t'(n), win_t'(0));
        tick();
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        int n = 0;
        b_valid = 1'b1; b_data = d; b_last = last;
        while (!b_ready && n < LIM) begin tick(); n++; end
        if (n >= LIM) chk("b_send_timeout", win_t'(n), win_t'(0));
        tick();
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst_n is low
        #12;
        chk("rst_ready", a_ready, NPAD == 0);
        chk("rst_wen", a_wen, NPAD > 0);
        chk("rst_valid", a_wvalid, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_err", a_err, 0);
        #4 rst_n = 1'b1;

`ifdef FEEDER_ZPAD_EN
        for (int i = 0; i < PAD; i++) begin
            chk("pad_wen", a_wen, 1);
            chk("pad_din", a_din, 0);
            chk("pad_ready", a_ready, 0);
            tick();
        end
        chk("pad_done_ready", a_ready, 1);
`endif

        // First window of the row
        for (int v = 1; v < NSTREAM; v++) send_a(8'(v), 1'b0);
        chk("w0_early_valid", a_wvalid, 0);
        send_a(8'(NSTREAM), 1'b0);
        chk("w0_valid", a_wvalid, 1);
        chk("w0_window", a_win, exp_win(NPAD, 1));
        chk("w0_idx", a_idx, 0);

        // Stall: engine holds the window with the stream pushing
        a_valid = 1'b1; a_data = 8'hAA;
        repeat (50) begin
            tick();
            if (a_ready || a_wen) holdbad++;
        end
        a_valid = 1'b0;
        chk("hold_stall", holdbad, 0);
        chk("hold_window", a_win, exp_win(NPAD, 1));
        chk("hold_valid", a_wvalid, 1);

        // Ack mid-row, then a stray ack in FILL
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        chk("ack_valid", a_wvalid, 0);
        chk("ack_idx", a_idx, 1);
        chk("ack_ready", a_ready, 1);
        a_ack = 1'b1; tick(); a_ack = 1'b0; tick();
        chk("stray_ack_idx", a_idx, 1);
        chk("stray_ack_valid", a_wvalid, 0);

        // Second window closes the row
        send_a(8'(NSTREAM + 1), 1'b1);
        e_win = (NPAD > 0) ? exp_win(NPAD - 1, 1) : exp_win(0, 2);
        chk("w1_valid", a_wvalid, 1);
        chk("w1_window", a_win, e_win);
        chk("w1_idx", a_idx, 1);
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        chk("rowend_idx", a_idx, 0);
        chk("rowend_valid", a_wvalid, 0);
        chk("rowend_ready", a_ready, NPAD == 0);

        // Short row: s_last on the 5th byte
        for (int v = 1; v <= 4; v++) send_a(8'(8'h20 + v), 1'b0);
        send_a(8'h25, 1'b1);
        chk("rowerr_pulse", a_err, 1);
        chk("rowerr_valid", a_wvalid, 0);
        tick();
        chk("rowerr_clear", a_err, 0);
        for (int v = 0; v < NSTREAM - 1; v++) send_a(8'(8'h30 + v), 1'b0);
        chk("rowerr_refill_early", a_wvalid, 0);
        send_a(8'(8'h30 + NSTREAM - 1), 1'b0);
        chk("rowerr_refill_valid", a_wvalid, 1);
        chk("rowerr_refill_window", a_win, exp_win(NPAD, 8'h30));
        chk("rowerr_refill_idx", a_idx, 0);

        // Minimum turnaround: ack with the next byte already waiting
        e_win = {8'h50, a_win[WIN*8-1:8]};
        a_valid = 1'b1; a_data = 8'h50; a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("turn_fill_valid", a_wvalid, 0);
        chk("turn_fill_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        chk("turn_valid", a_wvalid, 1);
        chk("turn_window", a_win, e_win);
        chk("turn_idx", a_idx, 1);

        // Asynchronous reset while in FILL
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        chk("prerst_idx", a_idx, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_idx", a_idx, 0);
        chk("arst_valid", a_wvalid, 0);
        chk("arst_err", a_err, 0);
        chk("arst_ready", a_ready, NPAD == 0);
        tick();
        rst_n = 1'b1;
        for (int v = 0; v < NSTREAM - 1; v++) send_a(8'(8'h70 + v), 1'b0);
        chk("arst_refill_early", a_wvalid, 0);
        send_a(8'(8'h70 + NSTREAM - 1), 1'b0);
        chk("arst_refill_valid", a_wvalid, 1);
        chk("arst_refill_window", a_win, exp_win(NPAD, 8'h70));
        chk("arst_refill_idx", a_idx, 0);

        // STRIDE=4 instance
        for (int v = 1; v <= NSTREAM; v++) send_b(8'(v), 1'b0);
        chk("s4_w0_valid", b_wvalid, 1);
        chk("s4_w0_window", b_win, exp_win(NPAD, 1));
        b_ack = 1'b1; tick(); b_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_b(8'(NSTREAM + i), 1'b0);
            chk("s4_stride_valid", b_wvalid, i == 4);
        end
        e_win = (NPAD >= 4) ? exp_win(NPAD - 4, 1) : exp_win(0, 5 - NPAD);
        chk("s4_w1_window", b_win, e_win);
        chk("s4_w1_idx", b_idx, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
